// File: rtl/sar_key_loader.sv
// -----------------------------------------------------------------------------
// sar_key_loader
//
// Upstream key stage for the SarLock-locked c17 netlist. It receives the
// KEY_W-bit key serially (LSB first) followed by one even-parity bit over a
// valid/ready link. A key that passes parity is committed in one step to a
// registered key bus that drives keyinput0..keyinput<KEY_W-1>. Until a good
// key is committed the bus is all-zero, which keeps the locked circuit
// corrupted. MAX_RETRY consecutive parity failures lock the loader out until
// reset.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   load_start in   one-cycle request to begin a key transfer
//   ser_data   in   serial key / parity bit
//   ser_valid  in   ser_data valid
//   ser_ready  out  loader accepts a bit this cycle
//   key_out    out  committed key, bit i -> keyinput<i>
//   key_valid  out  key_out holds a parity-checked key
//   key_err    out  last transfer failed parity
//   key_dead   out  retry limit reached, sticky until rst
//   busy       out  transfer or parity check in progress
//
// Every output comes straight from a flop; the flops that mirror the state
// (ser_ready, busy, key_dead) are loaded from the next-state value so they
// line up with the state register without any input-to-output path.
// -----------------------------------------------------------------------------
module sar_key_loader #(
  parameter int KEY_W     = 10,
  parameter int MAX_RETRY = 3,
  parameter bit RELOAD_EN = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_start,
  input  logic             ser_data,
  input  logic             ser_valid,
  output logic             ser_ready,
  output logic [KEY_W-1:0] key_out,
  output logic             key_valid,
  output logic             key_err,
  output logic             key_dead,
  output logic             busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SHIFT  = 3'd1,
    CHECK  = 3'd2,
    LOCKED = 3'd3,
    ERR    = 3'd4,
    DEAD   = 3'd5
  } state_t;

  // Bit counter must reach KEY_W (the parity slot).
  localparam int               CNT_W       = $clog2(KEY_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT    = CNT_W'(KEY_W);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [3:0]       MAX_RETRY_C = 4'(MAX_RETRY);
  localparam logic [KEY_W-1:0] KEY_ZERO    = {KEY_W{1'b0}};

  // Returns 1 when data plus its parity bit holds an odd number of ones,
  // i.e. the even-parity check fails.
  function automatic logic parity_fail(input logic [KEY_W-1:0] data,
                                       input logic             par);
    return (^data) ^ par;
  endfunction

  state_t             state_r, state_s;
  logic [CNT_W-1:0]   bit_cnt_r, bit_cnt_s;
  logic [KEY_W-1:0]   shadow_r, shadow_s;
  logic               parity_r, parity_s;
  logic [3:0]         retry_r, retry_s, retry_inc_s;
  logic [KEY_W-1:0]   key_out_r, key_out_s;
  logic               key_valid_r, key_valid_s;
  logic               key_err_r, key_err_s;
  logic               key_dead_r;
  logic               busy_r;
  logic               ser_ready_r;
  logic               xfer_s;

  // ser_ready_r is 1 exactly while the state register holds SHIFT.
  assign xfer_s = ser_valid & ser_ready_r;

  // Next-state and next-register logic; everything holds unless a state acts.
  always_comb begin
    state_s     = state_r;
    bit_cnt_s   = bit_cnt_r;
    shadow_s    = shadow_r;
    parity_s    = parity_r;
    retry_s     = retry_r;
    key_out_s   = key_out_r;
    key_valid_s = key_valid_r;
    key_err_s   = key_err_r;
    // Saturating increment so the counter can never wrap past the limit.
    if (retry_r >= MAX_RETRY_C) begin
      retry_inc_s = retry_r;
    end else begin
      retry_inc_s = retry_r + 4'd1;
    end

    case (state_r)
      IDLE: begin
        if (load_start) begin
          state_s   = SHIFT;
          bit_cnt_s = {CNT_W{1'b0}};
          shadow_s  = KEY_ZERO;
        end else begin
          state_s = IDLE;
        end
      end

      SHIFT: begin
        if (xfer_s) begin
          if (bit_cnt_r == LAST_BIT) begin
            parity_s = ser_data;
            state_s  = CHECK;
          end else begin
            // LSB first: transfer n lands in shadow bit n.
            shadow_s  = shadow_r | ({{(KEY_W-1){1'b0}}, ser_data} << bit_cnt_r);
            bit_cnt_s = bit_cnt_r + CNT_ONE;
          end
        end else begin
          state_s = SHIFT;
        end
      end

      CHECK: begin
        if (!parity_fail(shadow_r, parity_r)) begin
          key_out_s   = shadow_r;
          key_valid_s = 1'b1;
          key_err_s   = 1'b0;
          retry_s     = 4'd0;
          state_s     = LOCKED;
        end else begin
          key_err_s = 1'b1;
          retry_s   = retry_inc_s;
          if (retry_inc_s == MAX_RETRY_C) begin
            state_s     = DEAD;
            key_out_s   = KEY_ZERO;
            key_valid_s = 1'b0;
          end else begin
            // A failed re-key leaves the previously committed key in place.
            state_s = ERR;
          end
        end
      end

      LOCKED: begin
        if (load_start && RELOAD_EN) begin
          state_s   = SHIFT;
          bit_cnt_s = {CNT_W{1'b0}};
          shadow_s  = KEY_ZERO;
        end else begin
          state_s = LOCKED;
        end
      end

      ERR: begin
        if (load_start) begin
          state_s   = SHIFT;
          bit_cnt_s = {CNT_W{1'b0}};
          shadow_s  = KEY_ZERO;
          key_err_s = 1'b0;
        end else begin
          state_s = ERR;
        end
      end

      DEAD: begin
        state_s     = DEAD;
        key_out_s   = KEY_ZERO;
        key_valid_s = 1'b0;
      end

      default: begin
        // Illegal encoding: fall back to the safe, key-less idle state.
        state_s     = IDLE;
        bit_cnt_s   = {CNT_W{1'b0}};
        shadow_s    = KEY_ZERO;
        key_out_s   = KEY_ZERO;
        key_valid_s = 1'b0;
      end
    endcase
  end

  // State register, datapath registers and state-mirroring output flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      bit_cnt_r   <= {CNT_W{1'b0}};
      shadow_r    <= KEY_ZERO;
      parity_r    <= 1'b0;
      retry_r     <= 4'd0;
      key_out_r   <= KEY_ZERO;
      key_valid_r <= 1'b0;
      key_err_r   <= 1'b0;
      key_dead_r  <= 1'b0;
      busy_r      <= 1'b0;
      ser_ready_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      bit_cnt_r   <= bit_cnt_s;
      shadow_r    <= shadow_s;
      parity_r    <= parity_s;
      retry_r     <= retry_s;
      key_out_r   <= key_out_s;
      key_valid_r <= key_valid_s;
      key_err_r   <= key_err_s;
      key_dead_r  <= (state_s == DEAD);
      busy_r      <= (state_s == SHIFT) || (state_s == CHECK);
      ser_ready_r <= (state_s == SHIFT);
    end
  end

  assign ser_ready = ser_ready_r;
  assign key_out   = key_out_r;
  assign key_valid = key_valid_r;
  assign key_err   = key_err_r;
  assign key_dead  = key_dead_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_sar_key_loader.sv
// Bench for sar_key_loader: one write-once instance (wo_*) and one re-keyable
// instance (rk_*) share all inputs. Expected key/valid/err/dead values come
// from a small behavioural model and are queued when a stream is sent, then
// popped and compared once the result is due.
module tb_sar_key_loader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic load_start = 1'b0;
  logic ser_data = 1'b0;
  logic ser_valid = 1'b0;

  logic       wo_ser_ready, wo_key_valid, wo_key_err, wo_key_dead, wo_busy;
  logic [9:0] wo_key_out;
  logic       rk_ser_ready, rk_key_valid, rk_key_err, rk_key_dead, rk_busy;
  logic [9:0] rk_key_out;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [9:0] key;
    logic       valid;
    logic       err;
    logic       dead;
  } exp_t;
  exp_t sb_q[$];

  // behavioural model of the committed outputs
  logic [9:0] m_key;
  logic       m_valid, m_err, m_dead;
  int         m_retry;

  sar_key_loader #(.KEY_W(10), .MAX_RETRY(3), .RELOAD_EN(1'b0)) dut_wo (
    .clk(clk), .rst(rst), .load_start(load_start), .ser_data(ser_data),
    .ser_valid(ser_valid), .ser_ready(wo_ser_ready), .key_out(wo_key_out),
    .key_valid(wo_key_valid), .key_err(wo_key_err), .key_dead(wo_key_dead),
    .busy(wo_busy));

  sar_key_loader #(.KEY_W(10), .MAX_RETRY(3), .RELOAD_EN(1'b1)) dut_rk (
    .clk(clk), .rst(rst), .load_start(load_start), .ser_data(ser_data),
    .ser_valid(ser_valid), .ser_ready(rk_ser_ready), .key_out(rk_key_out),
    .key_valid(rk_key_valid), .key_err(rk_key_err), .key_dead(rk_key_dead),
    .busy(rk_busy));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_key = 10'h000; m_valid = 1'b0; m_err = 1'b0; m_dead = 1'b0; m_retry = 0;
    sb_q.delete();
  endtask

  // Model one completed transfer and queue the expected outcome.
  task automatic model_xfer(input logic [9:0] key, input logic par);
    if (((^key) ^ par) == 1'b0) begin
      m_key = key; m_valid = 1'b1; m_err = 1'b0; m_retry = 0;
    end else begin
      m_err = 1'b1;
      m_retry = m_retry + 1;
      if (m_retry == 3) begin
        m_dead = 1'b1; m_key = 10'h000; m_valid = 1'b0;
      end
    end
    sb_q.push_back({m_key, m_valid, m_err, m_dead});
  endtask

  task automatic sb_check(input string tag);
    exp_t e;
    check({tag, "_sb_depth"}, 16'(sb_q.size()), 16'd1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check({tag, "_wo_key"},   {6'd0, wo_key_out},   {6'd0, e.key});
      check({tag, "_wo_valid"}, {15'd0, wo_key_valid}, {15'd0, e.valid});
      check({tag, "_wo_err"},   {15'd0, wo_key_err},   {15'd0, e.err});
      check({tag, "_wo_dead"},  {15'd0, wo_key_dead},  {15'd0, e.dead});
      check({tag, "_rk_key"},   {6'd0, rk_key_out},   {6'd0, e.key});
      check({tag, "_rk_valid"}, {15'd0, rk_key_valid}, {15'd0, e.valid});
      check({tag, "_rk_err"},   {15'd0, rk_key_err},   {15'd0, e.err});
      check({tag, "_rk_dead"},  {15'd0, rk_key_dead},  {15'd0, e.dead});
    end
  endtask

  task automatic do_reset();
    ser_valid = 1'b0;
    load_start = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    model_reset();
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  // Drive one bit; when wait_rdy is set, hold it until the selected
  // instance (sel: 0 = wo, 1 = rk) shows ready, bounded to 40 cycles.
  task automatic send_bit(input logic b, input bit wait_rdy, input bit sel, input bit chk_wo_idle);
    int n;
    ser_data = b;
    ser_valid = 1'b1;
    n = 0;
    if (wait_rdy) begin
      while (((sel ? rk_ser_ready : wo_ser_ready) !== 1'b1) && n < 40) begin
        tick();
        n++;
      end
      check("ready_wait", {15'd0, (sel ? rk_ser_ready : wo_ser_ready)}, 16'd1);
    end
    if (chk_wo_idle) check("wo_ready_low", {15'd0, wo_ser_ready}, 16'd0);
    tick();
  endtask

  // Key LSB first then parity; stall_after >= 0 drops ser_valid for 5
  // cycles after that bit index.
  task automatic send_stream(input logic [9:0] key, input logic par, input bit wait_rdy,
                             input bit sel, input bit chk_wo_idle, input int stall_after);
    for (int i = 0; i < 10; i++) begin
      send_bit(key[i], wait_rdy, sel, chk_wo_idle);
      if (i == stall_after) begin
        ser_valid = 1'b0;
        for (int s = 0; s < 5; s++) begin
          tick();
          check("stall_ready", {15'd0, wo_ser_ready}, 16'd1);
          check("stall_busy",  {15'd0, wo_busy},      16'd1);
        end
      end
    end
    send_bit(par, wait_rdy, sel, chk_wo_idle);
    ser_valid = 1'b0;
  endtask

  initial begin
    // ---- reset state ----
    do_reset();
    check("rst_wo_key",   {6'd0, wo_key_out},    16'd0);
    check("rst_wo_valid", {15'd0, wo_key_valid}, 16'd0);
    check("rst_wo_err",   {15'd0, wo_key_err},   16'd0);
    check("rst_wo_dead",  {15'd0, wo_key_dead},  16'd0);
    check("rst_wo_busy",  {15'd0, wo_busy},      16'd0);
    check("rst_wo_ready", {15'd0, wo_ser_ready}, 16'd0);
    check("rst_rk_key",   {6'd0, rk_key_out},    16'd0);
    check("rst_rk_ready", {15'd0, rk_ser_ready}, 16'd0);

    // ---- good key ----
    pulse_start();
    check("shift_busy",  {15'd0, wo_busy},      16'd1);
    check("shift_ready", {15'd0, wo_ser_ready}, 16'd1);
    model_xfer(10'h296, 1'b1);
    send_stream(10'h296, 1'b1, 1'b1, 1'b0, 1'b0, -1);
    // one edge after parity: checking, key not yet required
    check("check_busy",  {15'd0, wo_busy},      16'd1);
    check("check_ready", {15'd0, wo_ser_ready}, 16'd0);
    tick();
    tick();
    sb_check("good");
    check("locked_busy", {15'd0, wo_busy}, 16'd0);

    // ---- stall after bit 4 ----
    do_reset();
    pulse_start();
    model_xfer(10'h296, 1'b1);
    send_stream(10'h296, 1'b1, 1'b1, 1'b0, 1'b0, 4);
    tick();
    tick();
    sb_check("stall");

    // ---- parity failure then retry ----
    do_reset();
    pulse_start();
    model_xfer(10'h296, 1'b0);
    send_stream(10'h296, 1'b0, 1'b1, 1'b0, 1'b0, -1);
    tick();
    tick();
    sb_check("badpar");
    check("err_busy", {15'd0, wo_busy}, 16'd0);
    pulse_start();
    check("err_clr_wo", {15'd0, wo_key_err}, 16'd0);
    check("err_clr_rk", {15'd0, rk_key_err}, 16'd0);
    model_xfer(10'h296, 1'b1);
    send_stream(10'h296, 1'b1, 1'b1, 1'b0, 1'b0, -1);
    tick();
    tick();
    sb_check("retry");

    // ---- write-once vs re-key (both hold 10'h296) ----
    pulse_start();
    check("wo_ignore_ready", {15'd0, wo_ser_ready}, 16'd0);
    check("rk_reload_ready", {15'd0, rk_ser_ready}, 16'd1);
    check("rk_old_key",      {6'd0, rk_key_out},    16'h0296);
    check("rk_old_valid",    {15'd0, rk_key_valid}, 16'd1);
    send_stream(10'h155, 1'b1, 1'b1, 1'b1, 1'b1, -1);
    tick();
    tick();
    check("wo_keeps_key",   {6'd0, wo_key_out},    16'h0296);
    check("wo_keeps_valid", {15'd0, wo_key_valid}, 16'd1);
    check("rk_new_key",     {6'd0, rk_key_out},    16'h0155);
    check("rk_new_valid",   {15'd0, rk_key_valid}, 16'd1);

    // ---- lockout after 3 bad transfers ----
    do_reset();
    for (int t = 0; t < 3; t++) begin
      pulse_start();
      model_xfer(10'h296, 1'b0);
      send_stream(10'h296, 1'b0, 1'b1, 1'b0, 1'b0, -1);
      tick();
      tick();
      sb_check("lockout");
    end
    check("dead_ready", {15'd0, wo_ser_ready}, 16'd0);
    pulse_start();
    send_stream(10'h296, 1'b1, 1'b0, 1'b0, 1'b0, -1);
    tick();
    tick();
    check("dead_stays",   {15'd0, wo_key_dead},  16'd1);
    check("dead_key",     {6'd0, wo_key_out},    16'd0);
    check("dead_valid",   {15'd0, wo_key_valid}, 16'd0);
    check("dead_ready2",  {15'd0, rk_ser_ready}, 16'd0);
    check("dead_busy",    {15'd0, rk_busy},      16'd0);

    // ---- async reset mid-shift ----
    do_reset();
    pulse_start();
    model_xfer(10'h296, 1'b1);
    send_stream(10'h296, 1'b1, 1'b1, 1'b0, 1'b0, -1);
    tick();
    tick();
    sb_check("pre_arst");
    pulse_start();
    for (int i = 0; i < 6; i++) send_bit(i[0], 1'b1, 1'b1, 1'b0);
    ser_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("arst_rk_key",   {6'd0, rk_key_out},    16'd0);
    check("arst_rk_valid", {15'd0, rk_key_valid}, 16'd0);
    check("arst_rk_busy",  {15'd0, rk_busy},      16'd0);
    check("arst_rk_ready", {15'd0, rk_ser_ready}, 16'd0);
    check("arst_wo_key",   {6'd0, wo_key_out},    16'd0);
    tick();
    rst = 1'b0;
    model_reset();
    pulse_start();
    model_xfer(10'h155, 1'b1);
    send_stream(10'h155, 1'b1, 1'b1, 1'b0, 1'b0, -1);
    tick();
    tick();
    sb_check("post_arst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
